win33_out_trans: RTL and testbench
==================================

# win33_out_trans

Winograd F(2x2,3x3) output-transform stage for the LeNet accelerator. Receives elementwise product tiles from the Winograd multiplier, accumulates them over input channels, computes Y = AᵀMA and hands each 2x2 result downstream via a valid/ready handshake. In dual mode it processes two tiles per beat. Dual mode covers two output channels sharing the same input tile.

## Interface
- ACC_W, 40, signed accumulator width per tile element
- OUT_W, 32, signed output element width (saturated)
- CH_W, 8, width of channel-count port
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_valid  in  1  product beat strobe (driven by multiplier end_signal)
- bitwidth  in  2  2'b00 single-tile mode, 2'b11 dual-tile mode; other codes are invalid
- m_tmp1, m_tmp2  in  256 each  tile A rows 0-1 / rows 2-3, eight signed 32-bit products each, MSB first, row-major
- m_tmp3, m_tmp4  in  256 each  tile B, same layout (ignored in single mode)
- ch_num  in  CH_W  tiles per accumulation group; 0 treated as 1
- relu_en  in  1  clamp negative outputs to 0
- y_valid  out  1  result available
- y_ready  in  1  downstream accepts result
- y_data  out  4*OUT_W  tile A result {Y00,Y01,Y10,Y11}, MSB first
- y_data_b  out  4*OUT_W  tile B result, same order; 0 in single mode
- y_dual  out  1  latched mode of the current result
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; a beat arrived while it could not be accepted

## Operation
- States: IDLE, ACC, ROW, COL, OUT.
- Beat acceptance:
  - A beat is accepted when m_valid=1 and either state is IDLE/ACC, or state is OUT with y_ready=1.
  - A beat with an invalid bitwidth in IDLE is ignored; it sets no flag.
  - In ACC, bitwidth is not re-sampled.
- First beat of a group:
  - Latches bitwidth (mode), relu_en, and max(ch_num,1).
  - Loads the accumulators with the sign-extended products.
  - Sets cnt=1.
  - Next state is ROW if cnt reaches the count, else ACC.
- Each further accepted beat adds its products elementwise to the accumulators and increments cnt.
  - When cnt reaches the count, go to ROW.
- ROW registers T = Aᵀ·acc, ACC_W+2 bits:
  - T0c = M0c + M1c + M2c
  - T1c = M1c − M2c − M3c
- COL registers Y = T·A, ACC_W+4 bits:
  - Yi0 = Ti0 + Ti1 + Ti2
  - Yi1 = Ti1 − Ti2 − Ti3
  - Each Y saturates to signed OUT_W, then ReLU is applied if latched relu_en=1.
  - y_valid is set; go to OUT.
- OUT: hold y_data, y_data_b and y_dual stable while y_valid=1 and y_ready=0.
  - Transfer occurs on an edge with y_valid & y_ready; go to IDLE.
  - If a beat is accepted on that same edge, it starts the next group instead of going to IDLE.
- A beat in ROW/COL, or in OUT without y_ready, is dropped and sets overrun.
- Single mode computes tile A only; tile B registers hold 0.
- Accumulator overflow wraps silently. ACC_W=40 covers ≥255 full-scale beats.

## Timing
- Reset values: y_valid=0, y_data=0, y_data_b=0, y_dual=0, busy=0, overrun=0; state IDLE, cnt=0, accumulators 0.
- Reset mid-group discards all partial sums; overrun is cleared only by reset.
- Latency: if the last beat of a group is accepted at edge E, then:
  - state is ROW after E
  - state is COL after E+1
  - y_valid=1 after E+2
- Throughput: one group per 3 cycles plus handshake wait. A new group can begin on the transfer edge.
- y_valid falls the cycle after transfer unless the next group's result is already registered (not possible: minimum gap 2 cycles).

## Test plan
- Single mode, ch_num=1, all 16 products = 1 -> y_valid 2 cycles after beat; y_data = {9,−3,−3,1}; y_data_b = 0; y_dual=0.
- ch_num=3, three beats with only M00=5 -> single result {15,0,0,0}; no y_valid after the first two beats.
- ch_num=4, all products 0x7FFFFFFF:
  - relu_en=0 -> {0x7FFFFFFF, 0x80000000, 0x80000000, 0x7FFFFFFF}
  - relu_en=1 -> {0x7FFFFFFF, 0, 0, 0x7FFFFFFF}
- Dual mode (bitwidth=11), tile A all 1, tile B all 2, ch_num=1 -> y_data {9,−3,−3,1}, y_data_b {18,−6,−6,2}, y_dual=1.
- Hold y_ready=0 for 5 cycles in OUT and pulse m_valid -> overrun=1, y_data unchanged. Then:
  - y_ready=1 with a simultaneous m_valid (ch_num=1, all 1) -> transfer plus a new result {9,−3,−3,1} 2 cycles later.
- ch_num=4, assert rst for one cycle after 2 beats -> all outputs 0, busy=0. A fresh 1-beat group then yields an uncontaminated result.

Source files
------------

// File: rtl/win33_out_trans.sv
// win33_out_trans: Winograd F(2x2,3x3) output transform.
// Accumulates 4x4 product tiles over ch_num beats, then computes
// Y = At * M * A in two registered steps (ROW, COL), saturates to OUT_W,
// optionally applies ReLU and presents the 2x2 result on a valid/ready port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   m_valid, bitwidth     product beat strobe, mode (00 single, 11 dual)
//   m_tmp1..m_tmp4        tile A rows 0-1/2-3, tile B rows 0-1/2-3 (MSB first)
//   ch_num, relu_en       beats per group (0 means 1), ReLU enable
//   y_valid, y_ready      result handshake
//   y_data, y_data_b      {Y00,Y01,Y10,Y11} for tile A / tile B
//   y_dual, busy, overrun latched mode, non-idle, sticky dropped-beat flag
module win33_out_trans #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 32,
    parameter int CH_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_valid,
    input  logic [1:0]         bitwidth,
    input  logic [255:0]       m_tmp1,
    input  logic [255:0]       m_tmp2,
    input  logic [255:0]       m_tmp3,
    input  logic [255:0]       m_tmp4,
    input  logic [CH_W-1:0]    ch_num,
    input  logic               relu_en,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [4*OUT_W-1:0] y_data,
    output logic [4*OUT_W-1:0] y_data_b,
    output logic               y_dual,
    output logic               busy,
    output logic               overrun
);
    localparam int TW = ACC_W + 2;
    localparam int YW = ACC_W + 4;
    localparam logic signed [YW-1:0] SAT_MAX = {{(YW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN = {{(YW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACC, ROW, COL, OUT} state_t;
    state_t state, state_nx;

    logic signed [31:0]    pa [16];
    logic signed [31:0]    pb [16];
    logic signed [ACC_W-1:0] acc_a [16];
    logic signed [ACC_W-1:0] acc_b [16];
    logic signed [TW-1:0]  t_a [8];
    logic signed [TW-1:0]  t_b [8];
    logic signed [YW-1:0]  ya [4];
    logic signed [YW-1:0]  yb [4];
    logic [CH_W-1:0]       cnt, tgt, ch_eff;
    logic                  mode, relu_q;
    logic                  bw_ok, can_start, acc_add, last_add, drop;

    function automatic logic [OUT_W-1:0] sat_relu(input logic signed [YW-1:0] v,
                                                  input logic relu);
        logic signed [YW-1:0] s;
        s = v;
        if (v > SAT_MAX) s = SAT_MAX;
        if (v < SAT_MIN) s = SAT_MIN;
        if (relu && s[YW-1]) s = '0;
        return s[OUT_W-1:0];
    endfunction

    // Unpack products: element k is row k/4, column k%4.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            pa[k]   = m_tmp1[255-32*k -: 32];
            pa[k+8] = m_tmp2[255-32*k -: 32];
            pb[k]   = m_tmp3[255-32*k -: 32];
            pb[k+8] = m_tmp4[255-32*k -: 32];
        end
    end

    assign bw_ok     = (bitwidth == 2'b00) || (bitwidth == 2'b11);
    assign ch_eff    = (ch_num == '0) ? CH_W'(1) : ch_num;
    // A new group can open in IDLE or on the OUT transfer edge.
    assign can_start = m_valid && bw_ok && (state == IDLE || (state == OUT && y_ready));
    assign acc_add   = m_valid && (state == ACC);
    assign last_add  = acc_add && ((cnt + CH_W'(1)) == tgt);
    assign drop      = m_valid && (state == ROW || state == COL || (state == OUT && !y_ready));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (can_start) state_nx = (ch_eff == CH_W'(1)) ? ROW : ACC;
            ACC:  if (last_add) state_nx = ROW;
            ROW:  state_nx = COL;
            COL:  state_nx = OUT;
            OUT:  if (y_ready) begin
                      if (can_start) state_nx = (ch_eff == CH_W'(1)) ? ROW : ACC;
                      else           state_nx = IDLE;
                  end
            default: state_nx = IDLE;
        endcase
    end

    // Column transform of the registered row result.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ya[2*i]   = YW'(t_a[4*i]) + YW'(t_a[4*i+1]) + YW'(t_a[4*i+2]);
            ya[2*i+1] = YW'(t_a[4*i+1]) - YW'(t_a[4*i+2]) - YW'(t_a[4*i+3]);
            yb[2*i]   = YW'(t_b[4*i]) + YW'(t_b[4*i+1]) + YW'(t_b[4*i+2]);
            yb[2*i+1] = YW'(t_b[4*i+1]) - YW'(t_b[4*i+2]) - YW'(t_b[4*i+3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            tgt      <= '0;
            mode     <= 1'b0;
            relu_q   <= 1'b0;
            overrun  <= 1'b0;
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_data_b <= '0;
            y_dual   <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                acc_a[k] <= '0;
                acc_b[k] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                t_a[k] <= '0;
                t_b[k] <= '0;
            end
        end else begin
            if (can_start) begin
                mode   <= (bitwidth == 2'b11);
                relu_q <= relu_en;
                tgt    <= ch_eff;
                cnt    <= CH_W'(1);
                for (int k = 0; k < 16; k++) begin
                    acc_a[k] <= ACC_W'(pa[k]);
                    // Tile B stays zero in single mode so its result reads 0.
                    acc_b[k] <= (bitwidth == 2'b11) ? ACC_W'(pb[k]) : '0;
                end
            end else if (acc_add) begin
                cnt <= cnt + CH_W'(1);
                for (int k = 0; k < 16; k++) begin
                    acc_a[k] <= acc_a[k] + ACC_W'(pa[k]);
                    if (mode) acc_b[k] <= acc_b[k] + ACC_W'(pb[k]);
                end
            end

            if (drop) overrun <= 1'b1;

            if (state == ROW) begin
                for (int c = 0; c < 4; c++) begin
                    t_a[c]   <= TW'(acc_a[c]) + TW'(acc_a[4+c]) + TW'(acc_a[8+c]);
                    t_a[4+c] <= TW'(acc_a[4+c]) - TW'(acc_a[8+c]) - TW'(acc_a[12+c]);
                    t_b[c]   <= TW'(acc_b[c]) + TW'(acc_b[4+c]) + TW'(acc_b[8+c]);
                    t_b[4+c] <= TW'(acc_b[4+c]) - TW'(acc_b[8+c]) - TW'(acc_b[12+c]);
                end
            end

            if (state == COL) begin
                y_data   <= {sat_relu(ya[0], relu_q), sat_relu(ya[1], relu_q),
                             sat_relu(ya[2], relu_q), sat_relu(ya[3], relu_q)};
                y_data_b <= {sat_relu(yb[0], relu_q), sat_relu(yb[1], relu_q),
                             sat_relu(yb[2], relu_q), sat_relu(yb[3], relu_q)};
                y_dual   <= mode;
                y_valid  <= 1'b1;
            end else if (state == OUT && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_win33_out_trans.sv
// Bench for win33_out_trans: scoreboard of expected 2x2 results computed
// from a direct At*M*A reference, popped as results are handed off.
module tb_win33_out_trans;
    logic         clk = 1'b0;
    logic         rst;
    logic         m_valid;
    logic [1:0]   bitwidth;
    logic [255:0] m_tmp1, m_tmp2, m_tmp3, m_tmp4;
    logic [7:0]   ch_num;
    logic         relu_en;
    logic         y_valid;
    logic         y_ready;
    logic [127:0] y_data, y_data_b;
    logic         y_dual, busy, overrun;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         dual;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    win33_out_trans dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .bitwidth(bitwidth),
        .m_tmp1(m_tmp1), .m_tmp2(m_tmp2), .m_tmp3(m_tmp3), .m_tmp4(m_tmp4),
        .ch_num(ch_num), .relu_en(relu_en), .y_valid(y_valid), .y_ready(y_ready),
        .y_data(y_data), .y_data_b(y_data_b), .y_dual(y_dual), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] fill(input logic [31:0] v);
        return {8{v}};
    endfunction

    function automatic longint prod(input logic [255:0] v, input int k);
        logic signed [31:0] p;
        p = v[255-32*k -: 32];
        return longint'(p);
    endfunction

    // Entry (i, r) of the transposed Winograd output matrix At.
    function automatic longint at(input int i, input int r);
        if (i == 0) return (r < 3) ? 64'sd1 : 64'sd0;
        return (r == 0) ? 64'sd0 : ((r == 1) ? 64'sd1 : -64'sd1);
    endfunction

    function automatic logic [127:0] model_y(input longint m[16], input bit relu);
        logic [127:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int rr = 0; rr < 4; rr++)
                    for (int c = 0; c < 4; c++)
                        s += at(i, rr) * m[rr*4+c] * at(j, c);
                if (s > 64'sd2147483647)  s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                if (relu && s < 0) s = 0;
                r[127-32*(2*i+j) -: 32] = s[31:0];
            end
        return r;
    endfunction

    // Drive n identical beats and push the expected result.
    task automatic group(input logic [255:0] t1, t2, t3, t4, input logic [1:0] bw,
                         input logic [7:0] ch, input bit relu, input int n);
        longint ma[16], mb[16];
        exp_t   e;
        bit     dual;
        dual = (bw == 2'b11);
        for (int k = 0; k < 16; k++) begin
            ma[k] = n * prod(k < 8 ? t1 : t2, k % 8);
            mb[k] = dual ? n * prod(k < 8 ? t3 : t4, k % 8) : 0;
        end
        e.a    = model_y(ma, relu);
        e.b    = dual ? model_y(mb, relu) : '0;
        e.dual = dual;
        sb.push_back(e);
        m_tmp1 = t1; m_tmp2 = t2; m_tmp3 = t3; m_tmp4 = t4;
        bitwidth = bw; ch_num = ch; relu_en = relu;
        for (int i = 0; i < n; i++) begin
            m_valid = 1'b1;
            @(posedge clk); #1;
            m_valid = 1'b0;
            if (i < n - 1) begin
                n_cmp++;
                if (y_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_valid beat %0d: got %b want 0", i, y_valid);
                end
            end
        end
    endtask

    // Wait for y_valid (expected two edges after the last beat) and check it.
    task automatic expect_result(input string name);
        int   lat;
        bit   got;
        exp_t e;
        lat = 0; got = 0;
        while (lat < 8 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (y_valid === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got || lat != 2) begin
            n_err++;
            $display("FAIL %s latency: got %0d (seen=%0d) want 2", name, lat, got);
        end
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s scoreboard: got empty want entry", name);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (y_data !== e.a) begin
                n_err++;
                $display("FAIL %s y_data: got %h want %h", name, y_data, e.a);
            end
            n_cmp++;
            if (y_data_b !== e.b) begin
                n_err++;
                $display("FAIL %s y_data_b: got %h want %h", name, y_data_b, e.b);
            end
            n_cmp++;
            if (y_dual !== e.dual) begin
                n_err++;
                $display("FAIL %s y_dual: got %b want %b", name, y_dual, e.dual);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(posedge clk); #1;
        n_cmp++;
        if (y_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: got valid=%b busy=%b want 0 0", name, y_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({y_valid, y_data, y_data_b, y_dual, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%h dual=%b busy=%b ovr=%b want all 0",
                     y_valid, y_data, y_data_b, y_dual, busy, overrun);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        // Tile B inputs carry junk that single mode must ignore.
        group(fill(1), fill(1), fill(7), fill(7), 2'b00, 8'd1, 1'b0, 1);
        n_cmp++;
        if (sb[0].a !== {32'd9, -32'sd3, -32'sd3, 32'd1}) begin
            n_err++;
            $display("FAIL ref_model_anchor: got %h want {9,-3,-3,1}", sb[0].a);
        end
        expect_result("single");
        check_idle("single");
        // ch_num = 0 behaves as a one-beat group.
        group(fill(32'hFFFF_FFFE), fill(3), '0, '0, 2'b00, 8'd0, 1'b0, 1);
        expect_result("ch_zero");
        check_idle("ch_zero");
    endtask

    task automatic test_invalid_bw();
        bitwidth = 2'b01; m_tmp1 = fill(1); m_tmp2 = fill(1); ch_num = 8'd1;
        m_valid = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_bw: got busy=%b ovr=%b want 0 0", busy, overrun);
        end
    endtask

    task automatic test_accum();
        logic [255:0] v;
        v = '0;
        v[255:224] = 32'd5;
        group(v, '0, '0, '0, 2'b00, 8'd3, 1'b0, 3);
        expect_result("accum");
        check_idle("accum");
    endtask

    task automatic test_saturate();
        group(fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF), '0, '0, 2'b00, 8'd4, 1'b0, 4);
        expect_result("sat");
        check_idle("sat");
        group(fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF), '0, '0, 2'b00, 8'd4, 1'b1, 4);
        expect_result("sat_relu");
        check_idle("sat_relu");
        group(fill(32'hFFFF_FFF0), fill(32'd5), '0, '0, 2'b00, 8'd2, 1'b1, 2);
        expect_result("relu_mixed");
        check_idle("relu_mixed");
    endtask

    task automatic test_dual();
        group(fill(1), fill(1), fill(2), fill(2), 2'b11, 8'd1, 1'b0, 1);
        expect_result("dual");
        check_idle("dual");
        group(fill(32'd4), fill(32'hFFFF_FFFD), fill(32'd11), fill(32'd6), 2'b11, 8'd2, 1'b0, 2);
        expect_result("dual_acc");
        check_idle("dual_acc");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        y_ready = 1'b0;
        group(fill(1), fill(1), '0, '0, 2'b00, 8'd1, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                m_tmp1 = fill(9); m_valid = 1'b1;
            end
            @(posedge clk); #1;
            m_valid = 1'b0;
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        n_cmp++;
        if (y_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_valid: got %b want 1", y_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if (y_data !== e.a || y_data_b !== e.b || y_dual !== e.dual) begin
            n_err++;
            $display("FAIL hold_data: got %h/%h/%b want %h/%h/%b",
                     y_data, y_data_b, y_dual, e.a, e.b, e.dual);
        end
        // Transfer and new first beat on the same edge.
        y_ready = 1'b1;
        group(fill(1), fill(1), '0, '0, 2'b00, 8'd1, 1'b0, 1);
        expect_result("b2b");
        check_idle("b2b");
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        m_tmp1 = fill(32'h1000); m_tmp2 = fill(32'h1000);
        bitwidth = 2'b00; ch_num = 8'd4; relu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_valid = 1'b1;
            @(posedge clk); #1;
            m_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({y_valid, y_data, y_data_b, y_dual, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b d=%h b=%h dual=%b busy=%b ovr=%b want all 0",
                     y_valid, y_data, y_data_b, y_dual, busy, overrun);
        end
        group(fill(1), fill(1), '0, '0, 2'b00, 8'd1, 1'b0, 1);
        expect_result("after_reset");
        check_idle("after_reset");
    endtask

    initial begin
        rst = 1'b1; m_valid = 1'b0; bitwidth = 2'b00; ch_num = 8'd1; relu_en = 1'b0;
        m_tmp1 = '0; m_tmp2 = '0; m_tmp3 = '0; m_tmp4 = '0; y_ready = 1'b1;
        test_reset();
        test_single();
        test_invalid_bw();
        test_accum();
        test_saturate();
        test_dual();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
